ibuf_seq_ctrl: RTL and testbench
================================

Name: ibuf_seq_ctrl

Overview:
Tile sequencer for the 4-column input buffer that feeds the MAC array. It accepts one tile command, streams exactly NCOL 32-bit words from a valid/ready source into the buffer columns, then holds the calculation-start enable for SHIFT_LEN cycles. It waits DRAIN_LEN cycles for the skewed shift chain to empty, then signals completion. It sits between the tile/DMA front end and the input buffer and drives all of the buffer's load/start/destination controls.

Parameters:
NCOL, 4, number of buffer columns (words per tile); IDST width fixed at 2, so NCOL ≤ 4
SHIFT_LEN, 4, cycles START_CALC is held high per tile (bytes per column)
DRAIN_LEN, 3, idle cycles after START_CALC falls before DONE (column skew NCOL-1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
CMD_VALID  in  1  tile command valid
CMD_READY  out  1  controller can accept a command (high only in IDLE)
CMD_ODST  in  4  output-destination tag for the tile
IN_VALID  in  1  source word valid
IN_READY  out  1  controller accepts a word (high only in LOAD)
IN_WORD  in  32  source word (4 packed bytes)
LOAD_EN  out  1  buffer write enable (registered)
IDST  out  2  buffer column select for LOAD_EN (registered)
IWORD  out  32  word to buffer (registered)
START_CALC  out  1  shift-chain start enable (registered)
ODST  out  4  tile destination tag to buffer
BUSY  out  1  high in any state except IDLE
DONE  out  1  one-cycle pulse, tile complete
TILE_CNT  out  16  completed tiles, wraps 0xFFFF→0

Behaviour:
- Reset (RST=1 at an edge, any state including mid-tile): next cycle state=IDLE. LOAD_EN=0, IDST=0, IWORD=0, START_CALC=0, ODST=0, BUSY=0, DONE=0, TILE_CNT=0, word counter=0. RST has priority over every other event.
- States:
  - IDLE → LOAD on CMD_VALID&CMD_READY. CMD_ODST is latched into ODST, which holds until the next accepted command.
  - LOAD: IN_READY=1 (combinational from state). Each IN_VALID&IN_READY registers IN_WORD→IWORD and count→IDST with LOAD_EN=1 the next cycle. Count increments 0..NCOL-1. If IN_VALID=0, the next cycle LOAD_EN=0 and IDST/IWORD hold. Accepting word NCOL-1 → ARM.
  - ARM: one cycle; the last write (IDST=NCOL-1) appears on the outputs this cycle.
  - CALC: START_CALC=1 for exactly SHIFT_LEN consecutive cycles, starting the cycle after ARM.
  - DRAIN: START_CALC=0 for DRAIN_LEN cycles; DRAIN_LEN=0 skips straight to DONE.
  - DONE state: DONE=1 for one cycle, TILE_CNT increments the same edge, then → IDLE.
- LOAD_EN and START_CALC are never high in the same cycle.
- CMD_VALID outside IDLE is ignored (CMD_READY=0). IN_VALID outside LOAD is ignored.
- Timing, command accepted at cycle t with IN_VALID held high:
  - words accepted t+1..t+4
  - LOAD_EN high t+2..t+5, IDST 0,1,2,3
  - START_CALC high t+6..t+9
  - DRAIN t+10..t+12
  - DONE high t+13
  - CMD_READY high again t+14
- Back-to-back commands: a command is accepted in the first IDLE cycle after DONE. Minimum tile period is 14 cycles at defaults.

Optional Feature:
IBUF_SEQ_STALL_CNT_EN:
- Defined: adds output STALL_CNT [15:0]. It increments each cycle state=LOAD and IN_VALID=0, saturates at 0xFFFF, and clears on RST only.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset then idle: RST high 2 cycles → all outputs 0, CMD_READY=1, IN_READY=0.
2. Single tile: CMD_ODST=4'b0100 at t, words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C streamed continuously → LOAD_EN t+2..t+5 with IDST 0..3 and matching IWORD; START_CALC t+6..t+9; DONE at t+13; ODST=4'b0100 throughout; TILE_CNT=1.
3. Source stalls: IN_VALID low for 3 cycles after word 1 → LOAD_EN low 3 cycles, IDST holds at 1. All later milestones shift by +3 (DONE at t+16). STALL_CNT=3 when the macro is defined.
4. Command during busy: CMD_VALID held high with a new tag through tile 1 → second accept exactly at t+14. ODST changes only then. DONE pulses at t+13 and t+27.
5. Reset mid-CALC: RST at t+7 → START_CALC=0 and BUSY=0 the next cycle, TILE_CNT=0. A fresh tile afterwards runs exactly as in scenario 2.
6. TILE_CNT wrap: force 0xFFFF via 65535 tiles or backdoor, run one tile → TILE_CNT=0x0000.

Source files
------------

// File: rtl/ibuf_seq_ctrl_if.sv
// Control/data bundle between the tile front end (master) and ibuf_seq_ctrl (slave).
// STALL_CNT is present only when IBUF_SEQ_STALL_CNT_EN is defined.
interface ibuf_seq_ctrl_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ODST_W = 4;
  localparam int unsigned IDST_W = 2;
  localparam int unsigned CNT_W  = 16;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [ODST_W-1:0] CMD_ODST;
  logic              IN_VALID;
  logic              IN_READY;
  logic [WORD_W-1:0] IN_WORD;
  logic              LOAD_EN;
  logic [IDST_W-1:0] IDST;
  logic [WORD_W-1:0] IWORD;
  logic              START_CALC;
  logic [ODST_W-1:0] ODST;
  logic              BUSY;
  logic              DONE;
  logic [CNT_W-1:0]  TILE_CNT;
`ifdef IBUF_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0]  STALL_CNT;

  modport master (
    output CMD_VALID, CMD_ODST, IN_VALID, IN_WORD,
    input  CMD_READY, IN_READY, LOAD_EN, IDST, IWORD, START_CALC,
           ODST, BUSY, DONE, TILE_CNT, STALL_CNT
  );
  modport slave (
    input  CMD_VALID, CMD_ODST, IN_VALID, IN_WORD,
    output CMD_READY, IN_READY, LOAD_EN, IDST, IWORD, START_CALC,
           ODST, BUSY, DONE, TILE_CNT, STALL_CNT
  );
`else
  modport master (
    output CMD_VALID, CMD_ODST, IN_VALID, IN_WORD,
    input  CMD_READY, IN_READY, LOAD_EN, IDST, IWORD, START_CALC,
           ODST, BUSY, DONE, TILE_CNT
  );
  modport slave (
    input  CMD_VALID, CMD_ODST, IN_VALID, IN_WORD,
    output CMD_READY, IN_READY, LOAD_EN, IDST, IWORD, START_CALC,
           ODST, BUSY, DONE, TILE_CNT
  );
`endif
endinterface

// File: rtl/ibuf_seq_ctrl.sv
// Tile sequencer for the MAC input buffer: load NCOL words, run the shift chain, drain, report done.
// Optional IBUF_SEQ_STALL_CNT_EN adds a saturating count of source-starved LOAD cycles.
module ibuf_seq_ctrl #(
  parameter int unsigned NCOL      = 4,
  parameter int unsigned SHIFT_LEN = 4,
  parameter int unsigned DRAIN_LEN = 3
) (
  input  logic           CLK,
  input  logic           RST,
  ibuf_seq_ctrl_if.slave bus
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ODST_W  = 4;
  localparam int unsigned IDST_W  = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CYC_MAX = (SHIFT_LEN > DRAIN_LEN) ? SHIFT_LEN : DRAIN_LEN;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [IDST_W-1:0] LAST_WORD  = IDST_W'(NCOL - 1);
  localparam logic [CYC_W-1:0]  SHIFT_LAST = CYC_W'(SHIFT_LEN - 1);
  localparam logic [CYC_W-1:0]  DRAIN_LAST = CYC_W'((DRAIN_LEN == 0) ? 0 : DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_CALC, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q, state_nxt;
  logic [IDST_W-1:0]  word_cnt_q, word_cnt_nxt;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_nxt;
  logic               load_en_q, load_en_nxt;
  logic [IDST_W-1:0]  idst_q, idst_nxt;
  logic [WORD_W-1:0]  iword_q, iword_nxt;
  logic               start_calc_q, start_calc_nxt;
  logic [ODST_W-1:0]  odst_q, odst_nxt;
  logic               busy_q, busy_nxt;
  logic               done_q, done_nxt;
  logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_nxt;
`ifdef IBUF_SEQ_STALL_CNT_EN
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_nxt;
`endif

  // Next-state and next-output decode; status outputs are registered from the next state.
  always_comb begin
    state_nxt    = state_q;
    word_cnt_nxt = word_cnt_q;
    cyc_cnt_nxt  = cyc_cnt_q;
    load_en_nxt  = 1'b0;
    idst_nxt     = idst_q;
    iword_nxt    = iword_q;
    odst_nxt     = odst_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          state_nxt    = S_LOAD;
          odst_nxt     = bus.CMD_ODST;
          word_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        if (bus.IN_VALID) begin
          load_en_nxt = 1'b1;
          idst_nxt    = word_cnt_q;
          iword_nxt   = bus.IN_WORD;
          if (word_cnt_q == LAST_WORD) begin
            state_nxt    = S_ARM;
            word_cnt_nxt = '0;
          end else begin
            word_cnt_nxt = word_cnt_q + IDST_W'(1);
          end
        end
      end
      S_ARM: begin
        state_nxt   = S_CALC;
        cyc_cnt_nxt = '0;
      end
      S_CALC: begin
        if (cyc_cnt_q == SHIFT_LAST) begin
          cyc_cnt_nxt = '0;
          state_nxt   = (DRAIN_LEN == 0) ? S_DONE : S_DRAIN;
        end else begin
          cyc_cnt_nxt = cyc_cnt_q + CYC_W'(1);
        end
      end
      S_DRAIN: begin
        if (cyc_cnt_q == DRAIN_LAST) begin
          cyc_cnt_nxt = '0;
          state_nxt   = S_DONE;
        end else begin
          cyc_cnt_nxt = cyc_cnt_q + CYC_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    start_calc_nxt = (state_nxt == S_CALC);
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state_nxt == S_DONE);
    tile_cnt_nxt   = done_nxt ? tile_cnt_q + CNT_W'(1) : tile_cnt_q;

`ifdef IBUF_SEQ_STALL_CNT_EN
    stall_cnt_nxt = stall_cnt_q;
    if ((state_q == S_LOAD) && !bus.IN_VALID && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_nxt = stall_cnt_q + CNT_W'(1);
`endif
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      load_en_q    <= 1'b0;
      idst_q       <= '0;
      iword_q      <= '0;
      start_calc_q <= 1'b0;
      odst_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tile_cnt_q   <= '0;
`ifdef IBUF_SEQ_STALL_CNT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_nxt;
      word_cnt_q   <= word_cnt_nxt;
      cyc_cnt_q    <= cyc_cnt_nxt;
      load_en_q    <= load_en_nxt;
      idst_q       <= idst_nxt;
      iword_q      <= iword_nxt;
      start_calc_q <= start_calc_nxt;
      odst_q       <= odst_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      tile_cnt_q   <= tile_cnt_nxt;
`ifdef IBUF_SEQ_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_nxt;
`endif
    end
  end

  assign bus.CMD_READY  = (state_q == S_IDLE);
  assign bus.IN_READY   = (state_q == S_LOAD);
  assign bus.LOAD_EN    = load_en_q;
  assign bus.IDST       = idst_q;
  assign bus.IWORD      = iword_q;
  assign bus.START_CALC = start_calc_q;
  assign bus.ODST       = odst_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.TILE_CNT   = tile_cnt_q;
`ifdef IBUF_SEQ_STALL_CNT_EN
  assign bus.STALL_CNT  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ibuf_seq_ctrl.sv
// Bench for ibuf_seq_ctrl: per-cycle stimulus records carry expected outputs into a
// scoreboard queue that is drained and compared on each falling clock edge.
module tb_ibuf_seq_ctrl;
  localparam int unsigned NCOL      = 4;
  localparam int unsigned SHIFT_LEN = 4;
  localparam int unsigned DRAIN_LEN = 3;

  localparam logic [31:0] W0 = 32'h03020100;
  localparam logic [31:0] W1 = 32'h07060504;
  localparam logic [31:0] W2 = 32'h0B0A0908;
  localparam logic [31:0] W3 = 32'h0F0E0D0C;

  typedef struct packed {
    logic        cmd_ready;
    logic        in_ready;
    logic        load_en;
    logic [1:0]  idst;
    logic [31:0] iword;
    logic        start_calc;
    logic [3:0]  odst;
    logic        busy;
    logic        done;
    logic [15:0] tile_cnt;
  } out_t;

  typedef struct packed {
    logic [7:0]  scen;
    logic [7:0]  k;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_odst;
    logic        in_valid;
    logic [31:0] in_word;
    out_t        exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t sb_q[$];

  // Expected values of the holding registers, carried between sequences.
  logic [1:0]  e_idst;
  logic [31:0] e_iword;
  logic [3:0]  e_odst;
  logic [15:0] e_tc;

  ibuf_seq_ctrl_if bus();

  ibuf_seq_ctrl #(
    .NCOL      (NCOL),
    .SHIFT_LEN (SHIFT_LEN),
    .DRAIN_LEN (DRAIN_LEN)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input int seed, input int j);
    logic [7:0] b;
    b = 8'(seed * 16 + j * 4);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("cr=%b ir=%b le=%b idst=%0d iword=%h sc=%b odst=%h busy=%b done=%b tc=%h",
                     o.cmd_ready, o.in_ready, o.load_en, o.idst, o.iword, o.start_calc,
                     o.odst, o.busy, o.done, o.tile_cnt);
  endfunction

  function automatic vec_t mk(input int scen, input int k, input int rst, input int cv,
                              input int co, input int iv, input logic [31:0] iw,
                              input int cr, input int ir, input int le, input int id,
                              input logic [31:0] iwe, input int sc, input int od,
                              input int bz, input int dn, input int tc);
    vec_t v;
    v = '0;
    v.scen = 8'(scen);  v.k = 8'(k);
    v.rst = 1'(rst);    v.cmd_valid = 1'(cv); v.cmd_odst = 4'(co);
    v.in_valid = 1'(iv); v.in_word = iw;
    v.exp.cmd_ready = 1'(cr); v.exp.in_ready = 1'(ir); v.exp.load_en = 1'(le);
    v.exp.idst = 2'(id); v.exp.iword = iwe; v.exp.start_calc = 1'(sc);
    v.exp.odst = 4'(od); v.exp.busy = 1'(bz); v.exp.done = 1'(dn);
    v.exp.tile_cnt = 16'(tc);
    return v;
  endfunction

  // Driver: inputs for one cycle go out just after the rising edge.
  task automatic apply(input vec_t v);
    @(posedge CLK);
    #1;
    RST           = v.rst;
    bus.CMD_VALID = v.cmd_valid;
    bus.CMD_ODST  = v.cmd_odst;
    bus.IN_VALID  = v.in_valid;
    bus.IN_WORD   = v.in_word;
    sb_q.push_back(v);
  endtask

  task automatic idle(input int scen);
    apply(mk(scen, 99, 0, 0, 0, 0, 32'h0, 1, 0, 0, int'(e_idst), e_iword, 0,
             int'(e_odst), 0, 0, int'(e_tc)));
  endtask

  // One tile from its accept cycle (k=0) built from the documented milestones.
  // s = source stall cycles after word 1; rst_at >= 0 asserts RST in that cycle and stops.
  task automatic run_tile(input int scen, input logic [3:0] tag, input int seed, input int s,
                          input logic keep, input logic [3:0] next_tag, input int rst_at);
    int   acc[4];
    int   last;
    vec_t v;
    acc  = '{1, 2, 3 + s, 4 + s};
    last = (rst_at >= 0) ? rst_at : 13 + s;
    for (int k = 0; k <= last; k++) begin
      v = '0;
      v.scen      = 8'(scen);
      v.k         = 8'(k);
      v.rst       = (k == rst_at);
      v.cmd_valid = (k == 0) ? 1'b1 : keep;
      v.cmd_odst  = (k == 0) ? tag : next_tag;
      v.in_valid  = !(k >= 1 && k <= 4 + s);
      v.in_word   = 32'hBAD0_0000 | 32'(k);
      for (int j = 0; j < 4; j++) begin
        if (k == acc[j]) begin
          v.in_valid = 1'b1;
          v.in_word  = word(seed, j);
        end
        if (k == acc[j] + 1) begin
          v.exp.load_en = 1'b1;
          e_idst  = 2'(j);
          e_iword = word(seed, j);
        end
      end
      if (k == 1)      e_odst = tag;
      if (k == 13 + s) e_tc   = e_tc + 16'd1;
      v.exp.cmd_ready  = (k == 0);
      v.exp.in_ready   = (k >= 1 && k <= 4 + s);
      v.exp.idst       = e_idst;
      v.exp.iword      = e_iword;
      v.exp.start_calc = (k >= 6 + s && k <= 9 + s);
      v.exp.odst       = e_odst;
      v.exp.busy       = (k >= 1);
      v.exp.done       = (k == 13 + s);
      v.exp.tile_cnt   = e_tc;
      apply(v);
    end
  endtask

  // Scoreboard: compare the oldest pending record against the DUT mid-cycle.
  always @(negedge CLK) begin : monitor
    vec_t v;
    out_t got;
    if (sb_q.size() != 0) begin
      v = sb_q.pop_front();
      got.cmd_ready  = bus.CMD_READY;
      got.in_ready   = bus.IN_READY;
      got.load_en    = bus.LOAD_EN;
      got.idst       = bus.IDST;
      got.iword      = bus.IWORD;
      got.start_calc = bus.START_CALC;
      got.odst       = bus.ODST;
      got.busy       = bus.BUSY;
      got.done       = bus.DONE;
      got.tile_cnt   = bus.TILE_CNT;
      n_chk++;
      if (got !== v.exp) begin
        n_fail++;
        $display("FAIL s%0d/k%0d outputs: got %s | expected %s",
                 v.scen, v.k, fmt(got), fmt(v.exp));
      end
    end
  end

  vec_t tbl[17];

  initial begin
    // Reset/idle and the single-tile reference (accept at t = row 2).
    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(2, 0, 0, 1, 4, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(2, 1, 0, 0, 0, 1, W0,            0, 1, 0, 0, 32'h0, 0, 4, 1, 0, 0);
    tbl[4]  = mk(2, 2, 0, 0, 0, 1, W1,            0, 1, 1, 0, W0,    0, 4, 1, 0, 0);
    tbl[5]  = mk(2, 3, 0, 0, 0, 1, W2,            0, 1, 1, 1, W1,    0, 4, 1, 0, 0);
    tbl[6]  = mk(2, 4, 0, 0, 0, 1, W3,            0, 1, 1, 2, W2,    0, 4, 1, 0, 0);
    tbl[7]  = mk(2, 5, 0, 0, 0, 0, 32'h0,         0, 0, 1, 3, W3,    0, 4, 1, 0, 0);
    tbl[8]  = mk(2, 6, 0, 0, 0, 0, 32'h0,         0, 0, 0, 3, W3,    1, 4, 1, 0, 0);
    tbl[9]  = mk(2, 7, 0, 0, 0, 0, 32'h0,         0, 0, 0, 3, W3,    1, 4, 1, 0, 0);
    tbl[10] = mk(2, 8, 0, 0, 0, 0, 32'h0,         0, 0, 0, 3, W3,    1, 4, 1, 0, 0);
    tbl[11] = mk(2, 9, 0, 0, 0, 0, 32'h0,         0, 0, 0, 3, W3,    1, 4, 1, 0, 0);
    tbl[12] = mk(2, 10, 0, 0, 0, 0, 32'h0,        0, 0, 0, 3, W3,    0, 4, 1, 0, 0);
    tbl[13] = mk(2, 11, 0, 0, 0, 0, 32'h0,        0, 0, 0, 3, W3,    0, 4, 1, 0, 0);
    tbl[14] = mk(2, 12, 0, 0, 0, 0, 32'h0,        0, 0, 0, 3, W3,    0, 4, 1, 0, 0);
    tbl[15] = mk(2, 13, 0, 0, 0, 0, 32'h0,        0, 0, 0, 3, W3,    0, 4, 1, 1, 1);
    tbl[16] = mk(2, 14, 0, 0, 0, 0, 32'h0,        1, 0, 0, 3, W3,    0, 4, 0, 0, 1);

    RST = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_ODST  = '0;
    bus.IN_VALID  = 1'b0;
    bus.IN_WORD   = '0;

    for (int i = 0; i < 17; i++) apply(tbl[i]);
    e_idst = 2'd3; e_iword = W3; e_odst = 4'h4; e_tc = 16'd1;

    // Source stalls three cycles after word 1.
    run_tile(3, 4'hA, 1, 3, 1'b0, 4'h0, -1);
    idle(3);
`ifdef IBUF_SEQ_STALL_CNT_EN
    @(negedge CLK);
    #1;
    n_chk++;
    if (bus.STALL_CNT !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d expected 3", bus.STALL_CNT);
    end
`endif

    // Command held through a busy tile is taken exactly in the next IDLE cycle.
    run_tile(4, 4'h5, 2, 0, 1'b1, 4'h6, -1);
    run_tile(4, 4'h6, 3, 0, 1'b0, 4'h0, -1);
    idle(4);

    // Reset in the middle of CALC, then a clean reference tile.
    run_tile(5, 4'h3, 4, 0, 1'b0, 4'h0, 7);
    e_idst = '0; e_iword = '0; e_odst = '0; e_tc = '0;
    idle(5);
    run_tile(5, 4'h4, 0, 0, 1'b0, 4'h0, -1);
    idle(5);

    // Tile counter wrap from 0xFFFF.
    @(negedge CLK);
    #1;
    force dut.tile_cnt_q = 16'hFFFF;
    @(posedge CLK);
    #1;
    release dut.tile_cnt_q;
    e_tc = 16'hFFFF;
    run_tile(6, 4'h9, 5, 0, 1'b0, 4'h0, -1);
    idle(6);

    repeat (2) @(negedge CLK);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d records left unchecked", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
